// File: rtl/ysyx_23060025_rd_arbiter.sv
// Round-robin read arbiter sharing one AXI4 AR/R channel between the icache (m0) and LSU (m1).
// state   | meaning
// IDLE    | arbitrate between pending psel requests
// ADDR    | axi_arvalid held from latched burst registers
// DATA    | axi_rready high, beats routed to granted master
// RELEASE | one dead cycle, psel ignored
module ysyx_23060025_rd_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] m0_paddr,
    input  logic                  m0_psel,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    output logic                  m0_rvalid,
    output logic                  m0_rlast,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [1:0]            m0_rresp,
    input  logic [ADDR_WIDTH-1:0] m1_paddr,
    input  logic                  m1_psel,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    output logic                  m1_rvalid,
    output logic                  m1_rlast,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [1:0]            m1_rresp,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    output logic [3:0]            axi_arid,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic [3:0]            axi_rid,
    output logic                  arb_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ADDR    = 2'd1,
        S_DATA    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [7:0]            beat_cnt_q, beat_cnt_d;
    logic                  pick;
    logic                  beat;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            size_q       <= size_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign beat = (state_q == S_DATA) && axi_rvalid;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        len_d        = len_q;
        size_d       = size_q;
        beat_cnt_d   = beat_cnt_q;
        // On a tie the master that did not win last time goes first.
        pick         = (m0_psel && m1_psel) ? ~last_grant_q : m1_psel;
        case (state_q)
            S_IDLE: begin
                if (m0_psel || m1_psel) begin
                    grant_d      = pick;
                    last_grant_d = pick;
                    addr_d       = pick ? m1_paddr  : m0_paddr;
                    len_d        = pick ? m1_arlen  : m0_arlen;
                    size_d       = pick ? m1_arsize : m0_arsize;
                    beat_cnt_d   = '0;
                    state_d      = S_ADDR;
                end
            end
            S_ADDR: begin
                if (axi_arready) state_d = S_DATA;
            end
            S_DATA: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (axi_rlast) state_d = S_RELEASE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign axi_araddr  = addr_q;
    assign axi_arvalid = (state_q == S_ADDR);
    assign axi_arlen   = len_q;
    assign axi_arsize  = size_q;
    assign axi_arburst = 2'b01;
    assign axi_arid    = {3'b000, grant_q};
    assign axi_rready  = (state_q == S_DATA);

    assign m0_rvalid = beat && !grant_q;
    assign m1_rvalid = beat &&  grant_q;
    assign m0_rlast  = m0_rvalid && axi_rlast;
    assign m1_rlast  = m1_rvalid && axi_rlast;
    assign m0_rdata  = axi_rdata;
    assign m1_rdata  = axi_rdata;
    assign m0_rresp  = axi_rresp;
    assign m1_rresp  = axi_rresp;

    // Errors are flagged but the beat is still forwarded and rlast still ends the burst.
    assign arb_err = beat && ((axi_rid != {3'b000, grant_q}) ||
                              (axi_rlast != (beat_cnt_q == len_q)));

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Bench for ysyx_23060025_rd_arbiter: burst table plus hand-written tie, back-to-back and reset sequences.
module tb_ysyx_23060025_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] m0_paddr, m1_paddr;
    logic        m0_psel, m1_psel;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic        m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp;
    logic [31:0] axi_araddr;
    logic        axi_arvalid, axi_arready;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic [3:0]  axi_arid;
    logic        axi_rvalid, axi_rready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic [3:0]  axi_rid;
    logic        arb_err;

    ysyx_23060025_rd_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clock(clock), .reset(reset),
        .m0_paddr(m0_paddr), .m0_psel(m0_psel), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_paddr(m1_paddr), .m1_psel(m1_psel), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_rvalid(m1_rvalid), .m1_rlast(m1_rlast), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arid(axi_arid), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rid(axi_rid), .arb_err(arb_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          m;
        logic [31:0] addr;
        int          len;
        logic [2:0]  size;
        int          ar_delay;
        int          nbeats;
        logic [3:0]  rid;
    } burst_t;

    typedef struct {
        bit          m;
        bit          rlast;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        bit          err;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    exp_t        sb[$];
    logic [31:0] cur_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every accepted beat must match the oldest expected beat.
    always @(negedge clock) begin
        if (mon_en) begin
            if (axi_rvalid && axi_rready) begin
                if (sb.size() == 0) begin
                    chk("beat_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("beat_ctrl", {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, arb_err},
                        {!e.m, e.m, !e.m && e.rlast, e.m && e.rlast, e.err});
                    chk("beat_data", e.m ? {m1_rresp, m1_rdata} : {m0_rresp, m0_rdata},
                        {e.rresp, e.rdata});
                end
            end else begin
                chk("quiet", {m0_rvalid, m1_rvalid, m0_rlast, m1_rlast, arb_err}, 0);
            end
        end
    end

    task automatic req(input bit m, input logic [31:0] addr, input int len, input logic [2:0] size);
        if (m) begin
            m1_paddr = addr; m1_arlen = len[7:0]; m1_arsize = size; m1_psel = 1'b1;
        end else begin
            m0_paddr = addr; m0_arlen = len[7:0]; m0_arsize = size; m0_psel = 1'b1;
        end
    endtask

    task automatic wait_ar(input bit m, input logic [31:0] addr, input int len,
                           input logic [2:0] size, input int lat);
        int k = 0;
        do begin
            @(negedge clock);
            k++;
        end while (!axi_arvalid && k < 20);
        chk("ar_seen", axi_arvalid, 1);
        chk("ar_latency", k, lat);
        chk("ar_fields", {axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid, axi_rready},
            {addr, len[7:0], size, 2'b01, 3'b000, m, 1'b0});
        cur_addr = addr;
    endtask

    task automatic do_ar(input int delay);
        repeat (delay) begin
            @(posedge clock);
            @(negedge clock);
            chk("ar_hold", {axi_arvalid, axi_araddr}, {1'b1, cur_addr});
        end
        axi_arready = 1'b1;
        @(posedge clock);
        #1 axi_arready = 1'b0;
    endtask

    task automatic do_beats(input bit m, input int len, input int nbeats, input logic [3:0] rid,
                            input bit with_last, input bit drop);
        for (int i = 0; i < nbeats; i++) begin
            exp_t e;
            axi_rvalid = 1'b1;
            axi_rdata  = $urandom;
            axi_rresp  = 2'($urandom_range(0, 3));
            axi_rlast  = with_last && (i == nbeats - 1);
            axi_rid    = rid;
            e.m     = m;
            e.rlast = axi_rlast;
            e.rdata = axi_rdata;
            e.rresp = axi_rresp;
            e.err   = (rid != {3'b000, m}) || (axi_rlast != (i == len));
            sb.push_back(e);
            @(posedge clock);
            #1;
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        if (drop) begin
            if (m) m1_psel = 1'b0; else m0_psel = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    burst_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{m: 1'b0, addr: 32'h8000_0010, len: 3, size: 3'd2, ar_delay: 2, nbeats: 4, rid: 4'd0};
        tbl[1] = '{m: 1'b1, addr: 32'h0000_1000, len: 0, size: 3'd2, ar_delay: 0, nbeats: 1, rid: 4'd1};
        tbl[2] = '{m: 1'b0, addr: 32'h8000_0020, len: 3, size: 3'd2, ar_delay: 0, nbeats: 2, rid: 4'd0};
        tbl[3] = '{m: 1'b0, addr: 32'h8000_0040, len: 1, size: 3'd2, ar_delay: 1, nbeats: 2, rid: 4'd1};
        tbl[4] = '{m: 1'b1, addr: 32'h0000_2000, len: 7, size: 3'd3, ar_delay: 1, nbeats: 8, rid: 4'd1};
        tbl[5] = '{m: 1'b1, addr: 32'h0000_3000, len: 1, size: 3'd1, ar_delay: 0, nbeats: 3, rid: 4'd1};

        reset = 1'b1;
        m0_paddr = '0; m0_psel = 1'b0; m0_arlen = '0; m0_arsize = '0;
        m1_paddr = '0; m1_psel = 1'b0; m1_arlen = '0; m1_arsize = '0;
        axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rid = '0;
        axi_rdata = '0; axi_rresp = '0;
        idle(2);
        mon_en    = 1'b1;
        axi_rdata = 32'hdead_beef;
        axi_rresp = 2'b10;
        @(negedge clock);
        chk("rst_axi", {axi_arvalid, axi_rready, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arid},
            {1'b0, 1'b0, 32'h0, 8'h0, 3'h0, 2'b01, 4'h0});
        chk("rst_rdata_follow", {m0_rdata, m1_rdata, m0_rresp, m1_rresp},
            {32'hdead_beef, 32'hdead_beef, 2'b10, 2'b10});
        @(posedge clock);
        #1 reset = 1'b0;

        // Tie after reset: m0 first, m1 AR two cycles after m0's last beat.
        req(0, 32'h8000_0100, 1, 3'd2);
        req(1, 32'h9000_0000, 2, 3'd2);
        wait_ar(0, 32'h8000_0100, 1, 3'd2, 2);
        do_ar(1);
        do_beats(0, 1, 2, 4'd0, 1, 1);
        wait_ar(1, 32'h9000_0000, 2, 3'd2, 3);
        do_ar(0);
        do_beats(1, 2, 3, 4'd1, 1, 1);
        idle(3);

        for (int i = 0; i < 6; i++) begin
            req(tbl[i].m, tbl[i].addr, tbl[i].len, tbl[i].size);
            wait_ar(tbl[i].m, tbl[i].addr, tbl[i].len, tbl[i].size, 2);
            do_ar(tbl[i].ar_delay);
            do_beats(tbl[i].m, tbl[i].len, tbl[i].nbeats, tbl[i].rid, 1, 1);
            idle(3);
        end

        // psel held one cycle past rlast must not produce a second AR.
        req(0, 32'h8000_2000, 1, 3'd2);
        wait_ar(0, 32'h8000_2000, 1, 3'd2, 2);
        do_ar(0);
        do_beats(0, 1, 2, 4'd0, 1, 0);
        @(posedge clock);
        #1 m0_psel = 1'b0;
        repeat (4) begin
            @(negedge clock);
            chk("b2b_no_dup_ar", axi_arvalid, 0);
        end
        @(posedge clock);
        #1 req(0, 32'h8000_2040, 0, 3'd2);
        wait_ar(0, 32'h8000_2040, 0, 3'd2, 2);
        do_ar(0);
        do_beats(0, 0, 1, 4'd0, 1, 1);
        idle(3);

        // Reset in DATA after one beat.
        req(0, 32'h8000_3000, 3, 3'd2);
        wait_ar(0, 32'h8000_3000, 3, 3'd2, 2);
        do_ar(0);
        do_beats(0, 3, 1, 4'd0, 0, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_before_edge", axi_rready, 1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_after", {axi_arvalid, axi_rready}, 2'b00);
        @(posedge clock);
        #1 req(1, 32'h4000_0000, 0, 3'd2);
        wait_ar(1, 32'h4000_0000, 0, 3'd2, 2);
        do_ar(0);
        do_beats(1, 0, 1, 4'd1, 1, 1);
        idle(3);

        chk("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
